shared_dff_arbiter: RTL and testbench

//   Round-robin arbiter and write sequencer for one shared WIDTH-bit D flip-flop register.
//   Up to N_REQ requesters compete to load the register; the block grants one requester
//   at a time, captures its data into the register, acknowledges it, then rotates priority.

---
 rtl/shared_dff_arbiter.sv | 112 +++++++++++
 tb/tb_shared_dff_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/shared_dff_arbiter.sv
// Round-robin arbiter and write sequencer for one shared WIDTH-bit register.
// One requester at a time is granted and its data is captured into q. The
// requester is then acknowledged, and priority rotates past it.
//
// Handshake: req[i] is a level request that stays high until ack[i] pulses.
// gnt[i] is high for the single GRANT cycle. The register loads at the edge
// that leaves GRANT, but only if req[i] is still high at that edge; a dropped
// request aborts the write. ack[i] is high for exactly one cycle (RELEASE).
// The requester must drop req[i] in that cycle, otherwise it is re-arbitrated
// at lowest priority.
module shared_dff_arbiter #(
  parameter int               N_REQ   = 4,
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       q,
  output logic                   busy,
  output logic [CNT_W-1:0]       wr_cnt,
  output logic [1:0]             state_dbg
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W:0]   N_L    = (IDX_W+1)'(N_REQ);
  localparam logic [IDX_W-1:0] LAST_L = IDX_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic [IDX_W:0]   cand;

  assign state_dbg = state;

  // Find the first active request, searching upward from ptr with wrap-around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= N_L) cand = cand - N_L;
      if (!win_found && req[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Sequencer: IDLE -> GRANT -> RELEASE -> IDLE. All outputs registered.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state  <= IDLE;
      ptr    <= '0;
      win    <= '0;
      gnt    <= '0;
      ack    <= '0;
      q      <= RST_VAL;
      busy   <= 1'b0;
      wr_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          if (win_found) begin
            win   <= win_idx;
            gnt   <= N_REQ'(1) << win_idx;
            busy  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          gnt   <= '0;
          state <= RELEASE;
          // A request withdrawn during GRANT aborts the write. Pointer, register
          // and counter keep their values.
          if (req[win]) begin
            q      <= wdata[win*WIDTH +: WIDTH];
            ack    <= N_REQ'(1) << win;
            wr_cnt <= wr_cnt + 1'b1;
            ptr    <= (win == LAST_L) ? '0 : win + 1'b1;
          end
        end
        RELEASE: begin
          ack   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          gnt   <= '0;
          ack   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_dff_arbiter.sv
// Bench for shared_dff_arbiter (N_REQ=4, WIDTH=8, RST_VAL=8'h3C, CNT_W=2).
module tb_shared_dff_arbiter;

  localparam logic [7:0] RST_V = 8'h3C;

  logic        clk;
  logic        rstb;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [7:0]  q;
  logic        busy;
  logic [1:0]  wr_cnt;
  logic [1:0]  state_dbg;

  int tests_run = 0;
  int tests_failed = 0;

  shared_dff_arbiter #(
    .N_REQ(4), .WIDTH(8), .RST_VAL(RST_V), .CNT_W(2)
  ) dut (
    .clk(clk), .rstb(rstb), .req(req), .wdata(wdata),
    .gnt(gnt), .ack(ack), .q(q), .busy(busy), .wr_cnt(wr_cnt),
    .state_dbg(state_dbg)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard helper.
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string name, input logic [3:0] e_gnt, input logic [3:0] e_ack,
                         input logic [7:0] e_q, input logic e_busy, input logic [1:0] e_cnt);
    chk({name, ".gnt"},    32'(gnt),    32'(e_gnt));
    chk({name, ".ack"},    32'(ack),    32'(e_ack));
    chk({name, ".q"},      32'(q),      32'(e_q));
    chk({name, ".busy"},   32'(busy),   32'(e_busy));
    chk({name, ".wr_cnt"}, 32'(wr_cnt), 32'(e_cnt));
  endtask

  // Driver: apply inputs, take one clock edge, check outputs #1 later.
  task automatic step_check(input string name, input logic r_n, input logic [3:0] r,
                            input logic [3:0] e_gnt, input logic [3:0] e_ack,
                            input logic [7:0] e_q, input logic e_busy, input logic [1:0] e_cnt);
    rstb = r_n;
    req  = r;
    @(posedge clk);
    #1;
    chk_all(name, e_gnt, e_ack, e_q, e_busy, e_cnt);
  endtask

  // Vector table: inputs for one cycle and the outputs expected after its edge.
  typedef struct {
    logic       rstb;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] ack;
    logic [7:0] q;
    logic       busy;
    logic [1:0] cnt;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic r_n, input logic [3:0] r, input logic [3:0] g,
                              input logic [3:0] a, input logic [7:0] qq, input logic b,
                              input logic [1:0] c);
    vec_t v;
    v.rstb = r_n; v.req = r; v.gnt = g; v.ack = a; v.q = qq; v.busy = b; v.cnt = c;
    return v;
  endfunction

  // Behavioural reference: phase 0 idle, 1 granted, 2 acknowledging.
  int         m_phase, m_w, m_ptr, m_cnt;
  logic [7:0] m_q;
  logic [3:0] m_gnt, m_ack;

  task automatic model_reset();
    m_phase = 0; m_w = 0; m_ptr = 0; m_cnt = 0;
    m_q = RST_V; m_gnt = 4'b0; m_ack = 4'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [31:0] d);
    bit found;
    case (m_phase)
      0: begin
        m_ack = 4'b0;
        found = 0;
        for (int k = 0; k < 4; k++) begin
          if (!found && r[(m_ptr + k) % 4]) begin
            found = 1;
            m_w = (m_ptr + k) % 4;
          end
        end
        if (found) begin
          m_gnt = 4'(1 << m_w);
          m_phase = 1;
        end
      end
      1: begin
        m_gnt = 4'b0;
        if (r[m_w]) begin
          m_q   = d[m_w*8 +: 8];
          m_ack = 4'(1 << m_w);
          m_cnt = (m_cnt + 1) % 4;
          m_ptr = (m_w + 1) % 4;
        end
        m_phase = 2;
      end
      default: begin
        m_ack = 4'b0;
        m_phase = 0;
      end
    endcase
  endtask

  initial begin
    // Reset with all requests active.
    rstb  = 1'b0;
    req   = 4'hF;
    wdata = {8'h44, 8'hA5, 8'h22, 8'h11};
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 4'b0, 4'b0, RST_V, 1'b0, 2'd0);

    // Single write from requester 2, then round robin from reset with counter wrap.
    vecs[0]  = mk(1, 4'b0100, 4'b0100, 4'b0000, RST_V, 1, 0);
    vecs[1]  = mk(1, 4'b0100, 4'b0000, 4'b0100, 8'hA5, 1, 1);
    vecs[2]  = mk(1, 4'b0000, 4'b0000, 4'b0000, 8'hA5, 0, 1);
    vecs[3]  = mk(1, 4'b0000, 4'b0000, 4'b0000, 8'hA5, 0, 1);
    vecs[4]  = mk(0, 4'b1111, 4'b0000, 4'b0000, RST_V, 0, 0);
    vecs[5]  = mk(1, 4'b1111, 4'b0001, 4'b0000, RST_V, 1, 0);
    vecs[6]  = mk(1, 4'b1111, 4'b0000, 4'b0001, 8'h11, 1, 1);
    vecs[7]  = mk(1, 4'b1111, 4'b0000, 4'b0000, 8'h11, 0, 1);
    vecs[8]  = mk(1, 4'b1111, 4'b0010, 4'b0000, 8'h11, 1, 1);
    vecs[9]  = mk(1, 4'b1111, 4'b0000, 4'b0010, 8'h22, 1, 2);
    vecs[10] = mk(1, 4'b1111, 4'b0000, 4'b0000, 8'h22, 0, 2);
    vecs[11] = mk(1, 4'b1111, 4'b0100, 4'b0000, 8'h22, 1, 2);
    vecs[12] = mk(1, 4'b1111, 4'b0000, 4'b0100, 8'hA5, 1, 3);
    vecs[13] = mk(1, 4'b1111, 4'b0000, 4'b0000, 8'hA5, 0, 3);
    vecs[14] = mk(1, 4'b1111, 4'b1000, 4'b0000, 8'hA5, 1, 3);
    vecs[15] = mk(1, 4'b1111, 4'b0000, 4'b1000, 8'h44, 1, 0);
    vecs[16] = mk(1, 4'b1111, 4'b0000, 4'b0000, 8'h44, 0, 0);
    vecs[17] = mk(1, 4'b1111, 4'b0001, 4'b0000, 8'h44, 1, 0);
    vecs[18] = mk(1, 4'b1111, 4'b0000, 4'b0001, 8'h11, 1, 1);
    vecs[19] = mk(1, 4'b0000, 4'b0000, 4'b0000, 8'h11, 0, 1);
    for (int i = 0; i < 20; i++) begin
      step_check($sformatf("vec%0d", i), vecs[i].rstb, vecs[i].req,
                 vecs[i].gnt, vecs[i].ack, vecs[i].q, vecs[i].busy, vecs[i].cnt);
    end

    // Withdraw during GRANT: no write, pointer stays at 0.
    step_check("wd_rst",   0, 4'b0000, 4'b0000, 4'b0000, RST_V, 0, 0);
    step_check("wd_gnt",   1, 4'b0010, 4'b0010, 4'b0000, RST_V, 1, 0);
    step_check("wd_drop",  1, 4'b0000, 4'b0000, 4'b0000, RST_V, 1, 0);
    step_check("wd_rel",   1, 4'b0000, 4'b0000, 4'b0000, RST_V, 0, 0);
    step_check("wd_g0",    1, 4'b0011, 4'b0001, 4'b0000, RST_V, 1, 0);
    step_check("wd_a0",    1, 4'b0011, 4'b0000, 4'b0001, 8'h11, 1, 1);
    step_check("wd_r0",    1, 4'b0010, 4'b0000, 4'b0000, 8'h11, 0, 1);
    step_check("wd_g1",    1, 4'b0010, 4'b0010, 4'b0000, 8'h11, 1, 1);
    step_check("wd_a1",    1, 4'b0010, 4'b0000, 4'b0010, 8'h22, 1, 2);
    step_check("wd_r1",    1, 4'b0000, 4'b0000, 4'b0000, 8'h22, 0, 2);

    // Asynchronous reset while requester 3 is granted.
    step_check("mr_gnt3",  1, 4'b1000, 4'b1000, 4'b0000, 8'h22, 1, 2);
    rstb = 1'b0;
    #2;
    chk_all("mr_async", 4'b0000, 4'b0000, RST_V, 1'b0, 2'd0);
    step_check("mr_hold",  0, 4'b1001, 4'b0000, 4'b0000, RST_V, 0, 0);
    step_check("mr_g0",    1, 4'b1001, 4'b0001, 4'b0000, RST_V, 1, 0);
    step_check("mr_a0",    1, 4'b1001, 4'b0000, 4'b0001, 8'h11, 1, 1);
    step_check("mr_r0",    1, 4'b0000, 4'b0000, 4'b0000, 8'h11, 0, 1);

    // Randomized traffic against the reference model.
    rstb = 1'b0;
    req  = 4'b0;
    @(posedge clk);
    #1;
    rstb = 1'b1;
    model_reset();
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 3) != 0) req = 4'($urandom_range(0, 15));
      wdata = $urandom;
      @(posedge clk);
      model_step(req, wdata);
      #1;
      chk_all($sformatf("rnd%0d", c), m_gnt, m_ack, m_q, (m_phase != 0), 2'(m_cnt));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
